// File: rtl/fb_pkg.sv
// Shared parameters, flush FSM encoding and memory address layout for the
// frame-buffer row sink.
package fb_pkg;

    localparam int unsigned N_COLS = 64;
    localparam int unsigned N_ROWS = 64;
    localparam int unsigned BPP    = 24;
    localparam int unsigned CW     = $clog2(N_COLS);
    localparam int unsigned RW     = $clog2(N_ROWS);

    // mem_addr = {slot, row, col}
    localparam int unsigned AW            = 1 + RW + CW;
    localparam int unsigned ADDR_COL_LSB  = 0;
    localparam int unsigned ADDR_ROW_LSB  = CW;
    localparam int unsigned ADDR_SLOT_BIT = CW + RW;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StXfer = 2'd2
    } flush_state_e;

endpackage

// File: rtl/fb_row_ram.sv
// Ping-pong row buffer: 2*N_COLS x BPP, one write port, one synchronous
// read port. No reset so it maps onto block RAM.
module fb_row_ram
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [CW:0]       waddr,
    input  logic [BPP-1:0]    wdata,
    input  logic              re,
    input  logic [CW:0]       raddr,
    output logic [BPP-1:0]    rdata
);

    logic [BPP-1:0] mem [2*N_COLS];

    // Write port and registered read port; rdata holds when re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fb_row_sink.sv
// Frame-buffer write sink: collects column writes into a ping-pong row
// buffer, flushes a stored row to the back frame slot over a ready/valid
// port, and swaps front/back slots on display vsync.
module fb_row_sink
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RW-1:0]     fbw_row_addr,
    input  logic              fbw_row_store,
    output logic              fbw_row_rdy,
    input  logic              fbw_row_swap,
    input  logic [BPP-1:0]    fbw_data,
    input  logic [CW-1:0]     fbw_col_addr,
    input  logic              fbw_wren,
    input  logic              frame_swap,
    output logic              frame_rdy,
    output logic [AW-1:0]     mem_addr,
    output logic [BPP-1:0]    mem_data,
    output logic              mem_we,
    input  logic              mem_rdy,
    input  logic              disp_vsync,
    output logic              disp_frame_sel
);

    flush_state_e     state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    flush_row_q;
    logic             flush_bank_q;
    logic             wr_bank_q;
    logic             swap_pending_q;
    logic             disp_sel_q;

    logic             idle;
    logic             store_ok;
    logic             swap_ok;
    logic             accept;
    logic             last;
    logic [CW-1:0]    cnt_inc;
    logic             ram_re;
    logic [CW:0]      ram_raddr;
    logic [BPP-1:0]   ram_rdata;

    assign idle     = (state_q == StIdle);
    assign store_ok = idle && fbw_row_store;
    assign swap_ok  = idle && fbw_row_swap;
    assign accept   = (state_q == StXfer) && mem_rdy;
    assign last     = (cnt_q == CW'(N_COLS - 1));
    assign cnt_inc  = cnt_q + CW'(1);

    // Read column cnt in READ; prefetch cnt+1 on each non-final accept so
    // beats stream back to back. Holding re low keeps mem_data stable.
    assign ram_re    = (state_q == StRead) || (accept && !last);
    assign ram_raddr = {flush_bank_q, (state_q == StRead) ? cnt_q : cnt_inc};

    fb_row_ram u_row_ram (
        .clk   (clk),
        .we    (fbw_wren),
        .waddr ({wr_bank_q, fbw_col_addr}),
        .wdata (fbw_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Flush FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (store_ok) state_d = StRead;
            StRead:  state_d = StXfer;
            StXfer:  if (accept && last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Flush outputs; address/data forced to zero outside XFER.
    always_comb begin
        fbw_row_rdy = idle;
        mem_we      = (state_q == StXfer);
        mem_addr    = '0;
        mem_data    = '0;
        if (mem_we) begin
            mem_addr = {~disp_sel_q, flush_row_q, cnt_q};
            mem_data = ram_rdata;
        end
    end

    // Column counter, latched store target and write-bank toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            flush_row_q  <= '0;
            flush_bank_q <= 1'b0;
            wr_bank_q    <= 1'b0;
        end else begin
            if (store_ok) begin
                // Latch pre-toggle bank when store and swap coincide.
                flush_bank_q <= wr_bank_q;
                flush_row_q  <= fbw_row_addr;
            end
            if (swap_ok) begin
                wr_bank_q <= ~wr_bank_q;
            end
            if (accept) begin
                cnt_q <= last ? '0 : cnt_inc;
            end
        end
    end

    // Frame swap arbitration against display vsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_pending_q <= 1'b0;
            disp_sel_q     <= 1'b0;
        end else if (disp_vsync && (swap_pending_q || frame_swap)) begin
            disp_sel_q     <= ~disp_sel_q;
            swap_pending_q <= 1'b0;
        end else if (frame_swap) begin
            swap_pending_q <= 1'b1;
        end
    end

    assign frame_rdy      = !swap_pending_q;
    assign disp_frame_sel = disp_sel_q;

endmodule

// File: doc/fb_row_sink.md
Name: fb_row_sink

Overview:
- Receiving end of the frame-buffer write interface. Accepts per-column pixel writes into a ping-pong row buffer.
- On a row store, flushes the completed row into a double-buffered frame memory through a ready/valid write port.
- Arbitrates frame swaps against the display scan-out vsync.
- Sits between the pattern/content producer and the frame memory that feeds the panel driver.

Parameters:
- N_COLS, 64, pixels per row (power of 2; CW = log2(N_COLS) = 6).
- N_ROWS, 64, rows per frame (power of 2; RW = log2(N_ROWS) = 6).
- BPP, 24, bits per pixel.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- fbw_row_addr  in  RW  row index latched on store.
- fbw_row_store  in  1  pulse: flush current write bank to frame memory at fbw_row_addr.
- fbw_row_rdy  out  1  high when the flush engine is idle and can take a store/swap.
- fbw_row_swap  in  1  pulse: toggle the write bank.
- fbw_data  in  BPP  pixel data.
- fbw_col_addr  in  CW  column index.
- fbw_wren  in  1  write fbw_data at fbw_col_addr into the write bank.
- frame_swap  in  1  pulse: back frame complete, request swap.
- frame_rdy  out  1  high when no swap is pending and the producer may start a frame.
- mem_addr  out  1+RW+CW  {frame_slot, row, col}.
- mem_data  out  BPP  pixel to memory.
- mem_we  out  1  write valid.
- mem_rdy  in  1  memory accepts; a transfer completes on the cycle mem_we && mem_rdy.
- disp_vsync  in  1  single-cycle frame boundary pulse from scan-out.
- disp_frame_sel  out  1  frame slot currently displayed (front).

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: fbw_row_rdy=1, frame_rdy=1, mem_we=0, mem_addr=0, mem_data=0, disp_frame_sel=0.
  - Internal: wr_bank=0, swap_pending=0.
  - Flush FSM forced to IDLE, abandoning any partial flush. Row buffer contents are undefined after reset.
- Back frame slot = ~disp_frame_sel. All flush writes target the back slot.
- Column writes: fbw_wren writes row buffer [wr_bank][fbw_col_addr] at the clock edge, in any FSM state.
- Store/swap: sampled only when fbw_row_rdy=1. If asserted while fbw_row_rdy=0, they are ignored with no state change.
  - Store latches flush_bank=wr_bank and flush_row=fbw_row_addr.
  - Swap toggles wr_bank.
  - When store and swap occur together, store latches the pre-toggle bank.
- Flush FSM: IDLE -> READ -> XFER -> IDLE.
  - IDLE: on an accepted store go to READ; fbw_row_rdy drops the next cycle.
  - READ: issue a synchronous buffer read (1-cycle latency) of column cnt.
  - XFER: mem_we=1, holding mem_data/mem_addr stable until mem_rdy.
    - On accept with cnt != N_COLS-1: cnt++ and go to READ (or prefetch).
    - On accept with cnt == N_COLS-1: go to IDLE; fbw_row_rdy=1 the next cycle.
  - With prefetch and mem_rdy held at 1, mem_we is continuous after the first beat.
- Timing with store at cycle T and mem_rdy=1:
  - fbw_row_rdy is low over T+1..T+65.
  - Col 0 presented at T+2; col 63 presented at T+65.
  - fbw_row_rdy returns high at T+66.
  - Each mem_rdy=0 cycle extends the flush by one cycle.
- A write into a bank being flushed is a producer protocol violation; the flushed data is undefined.
- Frame swap:
  - frame_swap sets swap_pending and drops frame_rdy the next cycle.
  - On disp_vsync with swap_pending: disp_frame_sel toggles, swap_pending clears, frame_rdy=1 the next cycle.
  - frame_swap and disp_vsync in the same cycle: swap executes at that edge; frame_rdy stays 1.
  - disp_vsync with no pending swap: no change, same frame redisplayed.
  - frame_swap while swap_pending=1: ignored.
- frame_swap arriving while a flush is active is a violation; the producer only swaps once fbw_row_rdy=1.
- Address packing: mem_addr = {back_slot, flush_row, cnt}, plain concatenation with no wrap arithmetic. cnt wraps to 0 on completion.

Decomposition:
- Package fb_pkg holds:
  - N_COLS, N_ROWS, BPP, CW, RW.
  - Flush FSM state encoding (IDLE=0, READ=1, XFER=2).
  - mem_addr field offsets.
- One sub-module, fb_row_ram: 2*N_COLS x BPP with one write port and one synchronous read port, mapped to block RAM.
- FSM, counters and swap logic stay in fb_row_sink.

Test Plan:
- Reset release -> fbw_row_rdy=1, frame_rdy=1, disp_frame_sel=0, mem_we=0; rst_n pulsed low mid-flush -> mem_we=0 immediately and fbw_row_rdy=1.
- Write cols 0..63 with data=0x0100*col+0x11 into bank 0, then store+swap at row 5, mem_rdy=1:
  - 64 writes to mem_addr {1,5,c}, c=0..63, data matching.
  - fbw_row_rdy low for exactly 65 cycles.
- Same row with mem_rdy toggling 1,0,1,0 -> 64 writes, no duplicate or missing columns, mem_data/mem_addr stable while stalled; fbw_row_rdy low 128+1 cycles.
- Back-to-back rows: fill bank 1 during the bank 0 flush, store row 6 when rdy returns -> row 6 written with bank 1 data; bank 0 contents are not reused.
- Store pulsed while fbw_row_rdy=0 -> ignored: no extra flush, flush_row unchanged.
- frame_swap then disp_vsync 10 cycles later:
  - frame_rdy low those 10 cycles; disp_frame_sel toggles 0->1 at vsync.
  - Next flush targets slot 0.
  - frame_swap coincident with disp_vsync -> immediate toggle, frame_rdy stays 1.
